// File: rtl/instr_fetch_pkg.sv
// Fetch-stage shared types: FSM state encoding, NOP encoding, reset PC.
// Also holds the target alignment helper used by the fetch FSM.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_RUN       = 2'd1,
        S_LOAD_WAIT = 2'd2,
        S_HALT      = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    function automatic logic misaligned(input logic [15:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: controller inputs, IMEM port and decode-side outputs.
// master = fetch stage, slave = controller/IMEM/decode side.
interface instr_fetch_if #(
    parameter int IMEM_AW = 14
);
    logic [15:0]        target_PC;
    logic               delay;
    logic               ecall;
    logic               resume;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [15:0]        PC;
    logic [31:0]        instruction;
    logic               instr_valid;
    logic               halted;
    logic               fetch_err;
    logic [31:0]        instret;

    modport master (
        input  target_PC, delay, ecall, resume, imem_rdata,
        output imem_addr, PC, instruction, instr_valid,
        output halted, fetch_err, instret
    );

    modport slave (
        output target_PC, delay, ecall, resume, imem_rdata,
        input  imem_addr, PC, instruction, instr_valid,
        input  halted, fetch_err, instret
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, IMEM address, load stall, ecall halt/resume,
// misaligned-target trap and retired-instruction counter. Ports: clk, rst_n, bus.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF,
    parameter int          IMEM_AW  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_if.master    bus
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         err_q, err_d;
    logic [31:0]  instret_q, instret_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        err_d     = err_q;
        instret_d = instret_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_LOAD_WAIT: begin
                if (misaligned(bus.target_PC)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (state_q == S_RUN && bus.ecall) begin
                    pc_d      = bus.target_PC;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_HALT;
                end else if (state_q == S_RUN && bus.delay) begin
                    // Hold PC so the load is re-presented for its 2nd cycle.
                    state_d = S_LOAD_WAIT;
                end else begin
                    pc_d      = bus.target_PC;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_RUN;
                end
            end
            S_HALT: begin
                if (bus.resume && !err_q) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            err_q     <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    // IMEM registers the read, so address it with next_pc to line up
    // imem_rdata with the PC register in the following cycle.
    assign bus.imem_addr   = pc_d[IMEM_AW+1:2];
    assign bus.PC          = pc_q;
    assign bus.instr_valid = (state_q == S_RUN) || (state_q == S_LOAD_WAIT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fetch_err   = err_q;
    assign bus.instret     = instret_q;
    assign bus.instruction = bus.instr_valid ? bus.imem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small registered-read IMEM model.
// Covers boot fill, straight-line, load stall, ecall/resume, trap, resets.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] mem [0:31];

    instr_fetch_if #(.IMEM_AW(14)) bus ();

    instr_fetch #(.RESET_PC(16'h0000), .IMEM_AW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h0010_0093;
        bus.target_PC = 16'h0000;
        bus.delay     = 1'b0;
        bus.ecall     = 1'b0;
        bus.resume    = 1'b0;
        rst_n         = 1'b0;
        #2;
        chk("rst_pc",    bus.PC, 32'h0);
        chk("rst_valid", bus.instr_valid, 32'h0);
        chk("rst_instr", bus.instruction, NOP_INSTR);
        chk("rst_halt",  bus.halted, 32'h0);
        chk("rst_err",   bus.fetch_err, 32'h0);
        chk("rst_iret",  bus.instret, 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("boot_valid", bus.instr_valid, 32'h0);
        chk("boot_instr", bus.instruction, NOP_INSTR);

        tick();
        chk("c2_pc",    bus.PC, 32'h0);
        chk("c2_instr", bus.instruction, 32'h0010_0093);
        chk("c2_valid", bus.instr_valid, 32'h1);

        bus.target_PC = 16'h0004;
        #1 chk("addr_next", bus.imem_addr, 32'h1);
        bus.target_PC = 16'hFFFC;
        #1 chk("addr_wrap", bus.imem_addr, 32'h3FFF);
        bus.target_PC = 16'h0004;
        tick();
        chk("pc4",  bus.PC, 32'h4);
        chk("ins4", bus.instruction, 32'h1000_0001);
        chk("ir1",  bus.instret, 32'd1);

        bus.target_PC = 16'h0008;
        tick();
        chk("pc8", bus.PC, 32'h8);
        chk("ir2", bus.instret, 32'd2);

        bus.target_PC = 16'h000C;
        bus.delay     = 1'b1;
        tick();
        chk("lw_pc",    bus.PC, 32'h8);
        chk("lw_valid", bus.instr_valid, 32'h1);
        chk("lw_instr", bus.instruction, 32'h1000_0002);
        chk("lw_ir",    bus.instret, 32'd2);

        tick();
        bus.delay = 1'b0;
        chk("pcC", bus.PC, 32'hC);
        chk("ir3", bus.instret, 32'd3);

        bus.target_PC = 16'h0010;
        tick();
        chk("pc10", bus.PC, 32'h10);
        chk("ir4",  bus.instret, 32'd4);

        bus.target_PC = 16'h0014;
        bus.ecall     = 1'b1;
        bus.resume    = 1'b1;
        tick();
        bus.ecall = 1'b0;
        chk("ec_halt",  bus.halted, 32'h1);
        chk("ec_valid", bus.instr_valid, 32'h0);
        chk("ec_instr", bus.instruction, NOP_INSTR);
        chk("ec_pc",    bus.PC, 32'h14);
        chk("ec_ir",    bus.instret, 32'd5);

        tick();
        bus.resume = 1'b0;
        chk("rs_halt",  bus.halted, 32'h0);
        chk("rs_pc",    bus.PC, 32'h14);
        chk("rs_valid", bus.instr_valid, 32'h1);
        chk("rs_instr", bus.instruction, 32'h1000_0005);

        bus.target_PC = 16'h0006;
        tick();
        chk("ma_err",  bus.fetch_err, 32'h1);
        chk("ma_halt", bus.halted, 32'h1);
        chk("ma_pc",   bus.PC, 32'h14);
        chk("ma_ir",   bus.instret, 32'd5);

        bus.resume = 1'b1;
        tick();
        tick();
        bus.resume = 1'b0;
        chk("ma_stuck", bus.halted, 32'h1);
        chk("ma_addr",  bus.imem_addr, 32'h5);

        rst_n = 1'b0;
        #1;
        chk("r2_err",  bus.fetch_err, 32'h0);
        chk("r2_halt", bus.halted, 32'h0);
        chk("r2_pc",   bus.PC, 32'h0);
        chk("r2_ir",   bus.instret, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("r2_run", bus.instr_valid, 32'h1);

        bus.target_PC = 16'h0004;
        tick();
        bus.target_PC = 16'h0008;
        bus.delay     = 1'b1;
        tick();
        chk("r3_lw_pc", bus.PC, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        bus.delay = 1'b0;
        chk("r3_pc",    bus.PC, 32'h0);
        chk("r3_valid", bus.instr_valid, 32'h0);
        chk("r3_instr", bus.instruction, NOP_INSTR);
        chk("r3_ir",    bus.instret, 32'd0);
        chk("r3_addr",  bus.imem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("r3_boot", bus.instr_valid, 32'h0);
        tick();
        chk("r3_run_pc", bus.PC, 32'h0);
        chk("r3_run_in", bus.instruction, 32'h0010_0093);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
